toy_bus_tgt_node: RTL and testbench

- Target-side endpoint of the toy_bus network. The inverse of the core-side initiator node.
- Accepts routed ToyBusReq packets (addr/data/strb/opcode/src_id/tgt_id) from the network, strips routing fields and drives a plain slave device request port.
- Returns the device's in-order responses as ToyBusAck packets: tgt_id = the originating src_id, src_id = own NODE_ID.
- Tracks up to OST_DEPTH outstanding transactions in an ID FIFO; request and ack paths each have a one-entry register slice.

---
 rtl/toy_bus_pkg.sv | 23 ++
 rtl/toy_bus_id_fifo.sv | 68 ++++++
 rtl/toy_bus_tgt_node.sv | 169 ++++++++++++++++
 tb/tb_toy_bus_tgt_node.sv | 655 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// Shared toy_bus definitions: field widths, opcode encodings and the node-id map.
package toy_bus_pkg;

  localparam int ID_W = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // System map of node ids
  localparam logic [ID_W-1:0] NODE_CORE0 = 4'd0;
  localparam logic [ID_W-1:0] NODE_CORE1 = 4'd1;
  localparam logic [ID_W-1:0] NODE_TGT0  = 4'd2;
  localparam logic [ID_W-1:0] NODE_TGT1  = 4'd3;

  // What a target must remember per outstanding request to build its ack
  typedef struct packed {
    logic [ID_W-1:0] src_id;
    logic            opcode;
  } id_entry_t;

  localparam int ID_ENTRY_W = $bits(id_entry_t);

endpackage

// File: rtl/toy_bus_id_fifo.sv
// Small synchronous FIFO for transaction ids. DEPTH must be a power of two so
// the pointers wrap for free. The caller never pushes when full or pops when empty.
module toy_bus_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: write at wr_ptr, advance pointers, count tracks push minus pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/toy_bus_tgt_node.sv
// Target-side toy_bus endpoint: strips routing from network requests toward a
// plain device port and wraps in-order device responses back into acks.
module toy_bus_tgt_node
  import toy_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] NODE_ID   = NODE_TGT0,
  parameter int              OST_DEPTH = 4,
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in0_req_vld,
  output logic                  in0_req_rdy,
  input  logic [ADDR_W-1:0]     in0_req_addr,
  input  logic [DATA_W-1:0]     in0_req_data,
  input  logic [DATA_W/8-1:0]   in0_req_strb,
  input  logic                  in0_req_opcode,
  input  logic [3:0]            in0_req_src_id,
  input  logic [3:0]            in0_req_tgt_id,
  output logic                  in0_ack_vld,
  input  logic                  in0_ack_rdy,
  output logic                  in0_ack_opcode,
  output logic [DATA_W-1:0]     in0_ack_data,
  output logic [3:0]            in0_ack_src_id,
  output logic [3:0]            in0_ack_tgt_id,
  output logic                  out0_req_vld,
  input  logic                  out0_req_rdy,
  output logic [ADDR_W-1:0]     out0_req_addr,
  output logic [DATA_W-1:0]     out0_req_data,
  output logic [DATA_W/8-1:0]   out0_req_strb,
  output logic                  out0_req_opcode,
  input  logic                  out0_ack_vld,
  output logic                  out0_ack_rdy,
  input  logic [DATA_W-1:0]     out0_ack_data,
  output logic                  err_misroute
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(OST_DEPTH) + 1;

  logic              req_full_q, req_full_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [STRB_W-1:0] req_strb_q, req_strb_d;
  logic              req_opcode_q, req_opcode_d;
  logic              ack_full_q, ack_full_d;
  logic [DATA_W-1:0] ack_data_q, ack_data_d;
  logic              ack_opcode_q, ack_opcode_d;
  logic [ID_W-1:0]   ack_tgt_q, ack_tgt_d;
  logic              err_q, err_d;

  logic              in_xfer;
  logic              dev_ack_xfer;
  id_entry_t         fifo_wdata;
  id_entry_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;

  // The FIFO count already includes the request parked in the slice, so the
  // outstanding limit covers everything the device has not yet answered.
  assign in0_req_rdy  = (!req_full_q || out0_req_rdy) && (fifo_cnt < CNT_W'(OST_DEPTH));
  assign out0_ack_rdy = !ack_full_q || in0_ack_rdy;
  assign in_xfer      = in0_req_vld && in0_req_rdy;
  assign dev_ack_xfer = out0_ack_vld && out0_ack_rdy;
  assign fifo_wdata   = '{src_id: in0_req_src_id, opcode: in0_req_opcode};

  toy_bus_id_fifo #(
    .DEPTH (OST_DEPTH),
    .WIDTH (ID_ENTRY_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_xfer),
    .wdata (fifo_wdata),
    .pop   (dev_ack_xfer),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Request slice: load on network accept, empty when the device takes it
  always_comb begin
    req_full_d   = req_full_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_strb_d   = req_strb_q;
    req_opcode_d = req_opcode_q;
    err_d        = err_q;
    if (in_xfer) begin
      req_full_d   = 1'b1;
      req_addr_d   = in0_req_addr;
      req_data_d   = in0_req_data;
      req_strb_d   = in0_req_strb;
      req_opcode_d = in0_req_opcode;
      if (in0_req_tgt_id != NODE_ID) begin
        err_d = 1'b1;
      end
    end else if (out0_req_rdy) begin
      req_full_d = 1'b0;
    end
  end

  // Ack slice: device response plus the popped id entry form the network ack
  always_comb begin
    ack_full_d   = ack_full_q;
    ack_data_d   = ack_data_q;
    ack_opcode_d = ack_opcode_q;
    ack_tgt_d    = ack_tgt_q;
    if (dev_ack_xfer) begin
      ack_full_d   = 1'b1;
      ack_data_d   = out0_ack_data;
      ack_opcode_d = fifo_head.opcode;
      ack_tgt_d    = fifo_head.src_id;
    end else if (in0_ack_rdy) begin
      ack_full_d = 1'b0;
    end
  end

  // State registers; reset drops every in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_full_q   <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_strb_q   <= '0;
      req_opcode_q <= 1'b0;
      ack_full_q   <= 1'b0;
      ack_data_q   <= '0;
      ack_opcode_q <= 1'b0;
      ack_tgt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      req_full_q   <= req_full_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_strb_q   <= req_strb_d;
      req_opcode_q <= req_opcode_d;
      ack_full_q   <= ack_full_d;
      ack_data_q   <= ack_data_d;
      ack_opcode_q <= ack_opcode_d;
      ack_tgt_q    <= ack_tgt_d;
      err_q        <= err_d;
    end
  end

  assign out0_req_vld    = req_full_q;
  assign out0_req_addr   = req_addr_q;
  assign out0_req_data   = req_data_q;
  assign out0_req_strb   = req_strb_q;
  assign out0_req_opcode = req_opcode_q;
  assign in0_ack_vld     = ack_full_q;
  assign in0_ack_data    = ack_data_q;
  assign in0_ack_opcode  = ack_opcode_q;
  assign in0_ack_tgt_id  = ack_tgt_q;
  assign in0_ack_src_id  = NODE_ID;
  assign err_misroute    = err_q;

  // A device response with nothing outstanding has no requester to return to
  a_ack_needs_entry: assert property (@(posedge clk) disable iff (!rst_n)
    dev_ack_xfer |-> !fifo_empty);

  // A full id FIFO must always stall the network side
  a_full_stalls: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> !in0_req_rdy);

endmodule

// File: tb/tb_toy_bus_tgt_node.sv
// Bench for toy_bus_tgt_node: directed scenarios plus randomized traffic
// scored against a transaction-level model.
module tb_toy_bus_tgt_node;

  logic        clk;
  logic        rst_n;
  logic        in0_req_vld;
  logic        in0_req_rdy;
  logic [31:0] in0_req_addr;
  logic [31:0] in0_req_data;
  logic [3:0]  in0_req_strb;
  logic        in0_req_opcode;
  logic [3:0]  in0_req_src_id;
  logic [3:0]  in0_req_tgt_id;
  logic        in0_ack_vld;
  logic        in0_ack_rdy;
  logic        in0_ack_opcode;
  logic [31:0] in0_ack_data;
  logic [3:0]  in0_ack_src_id;
  logic [3:0]  in0_ack_tgt_id;
  logic        out0_req_vld;
  logic        out0_req_rdy;
  logic [31:0] out0_req_addr;
  logic [31:0] out0_req_data;
  logic [3:0]  out0_req_strb;
  logic        out0_req_opcode;
  logic        out0_ack_vld;
  logic        out0_ack_rdy;
  logic [31:0] out0_ack_data;
  logic        err_misroute;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        op;
    logic [3:0]  src;
    logic [3:0]  tgt;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        op;
    logic [3:0]  src;
    logic [3:0]  tgt;
  } ack_t;

  req_t        mon_in[$];
  req_t        mon_out[$];
  logic [31:0] mon_dev_ack[$];
  ack_t        mon_ack[$];
  req_t        m_r;
  ack_t        m_a;

  toy_bus_tgt_node dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in0_req_vld     (in0_req_vld),
    .in0_req_rdy     (in0_req_rdy),
    .in0_req_addr    (in0_req_addr),
    .in0_req_data    (in0_req_data),
    .in0_req_strb    (in0_req_strb),
    .in0_req_opcode  (in0_req_opcode),
    .in0_req_src_id  (in0_req_src_id),
    .in0_req_tgt_id  (in0_req_tgt_id),
    .in0_ack_vld     (in0_ack_vld),
    .in0_ack_rdy     (in0_ack_rdy),
    .in0_ack_opcode  (in0_ack_opcode),
    .in0_ack_data    (in0_ack_data),
    .in0_ack_src_id  (in0_ack_src_id),
    .in0_ack_tgt_id  (in0_ack_tgt_id),
    .out0_req_vld    (out0_req_vld),
    .out0_req_rdy    (out0_req_rdy),
    .out0_req_addr   (out0_req_addr),
    .out0_req_data   (out0_req_data),
    .out0_req_strb   (out0_req_strb),
    .out0_req_opcode (out0_req_opcode),
    .out0_ack_vld    (out0_ack_vld),
    .out0_ack_rdy    (out0_ack_rdy),
    .out0_ack_data   (out0_ack_data),
    .err_misroute    (err_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer monitor, sampled mid-cycle while everything is settled
  always @(negedge clk) begin
    if (rst_n) begin
      if (in0_req_vld && in0_req_rdy) begin
        m_r = '{in0_req_addr, in0_req_data, in0_req_strb, in0_req_opcode,
                in0_req_src_id, in0_req_tgt_id};
        mon_in.push_back(m_r);
      end
      if (out0_req_vld && out0_req_rdy) begin
        m_r = '{out0_req_addr, out0_req_data, out0_req_strb, out0_req_opcode, 4'd0, 4'd0};
        mon_out.push_back(m_r);
      end
      if (out0_ack_vld && out0_ack_rdy) mon_dev_ack.push_back(out0_ack_data);
      if (in0_ack_vld && in0_ack_rdy) begin
        m_a = '{in0_ack_data, in0_ack_opcode, in0_ack_src_id, in0_ack_tgt_id};
        mon_ack.push_back(m_a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic op,
                           input logic [3:0] src, input logic [3:0] tgt);
    in0_req_vld    = 1'b1;
    in0_req_addr   = addr;
    in0_req_data   = data;
    in0_req_strb   = strb;
    in0_req_opcode = op;
    in0_req_src_id = src;
    in0_req_tgt_id = tgt;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in0_req_rdy) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in0_req_vld = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic op,
                          input logic [3:0] src, input logic [3:0] tgt, output bit ok);
    drive_req(addr, ~addr, 4'hF, op, src, tgt);
    wait_accept(ok);
  endtask

  task automatic dev_ack(input logic [31:0] data, output bit ok);
    out0_ack_vld  = 1'b1;
    out0_ack_data = data;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (out0_ack_rdy) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    out0_ack_vld = 1'b0;
  endtask

  task automatic apply_reset();
    in0_req_vld  = 1'b0;
    out0_ack_vld = 1'b0;
    out0_req_rdy = 1'b1;
    in0_ack_rdy  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    mon_in.delete();
    mon_out.delete();
    mon_dev_ack.delete();
    mon_ack.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in0_ack_vld !== 1'b0 || out0_req_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_vld: in0_ack_vld=%b out0_req_vld=%b required 0/0", in0_ack_vld, out0_req_vld);
    end
    checks++;
    if (err_misroute !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b required 0", err_misroute);
    end
    checks++;
    if (in0_req_rdy !== 1'b1 || out0_ack_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy: in0_req_rdy=%b out0_ack_rdy=%b required 1/1", in0_req_rdy, out0_ack_rdy);
    end
    checks++;
    if (in0_ack_src_id !== 4'd2 || out0_req_addr !== 32'h0 || in0_ack_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_payload: src_id=%h addr=%h ack_data=%h required 2/0/0",
               in0_ack_src_id, out0_req_addr, in0_ack_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    apply_reset();
    drive_req(32'h8000_0010, 32'h0, 4'h0, 1'b0, 4'd6, 4'd2);
    #1;
    checks++;
    if (in0_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL sr_req_rdy: got %b required 1", in0_req_rdy);
    end
    tick();
    in0_req_vld = 1'b0;
    checks++;
    if (out0_req_vld !== 1'b1 || out0_req_addr !== 32'h8000_0010 || out0_req_opcode !== 1'b0) begin
      failures++;
      $display("FAIL sr_out_req: vld=%b addr=%h op=%b required 1/80000010/0",
               out0_req_vld, out0_req_addr, out0_req_opcode);
    end
    tick();
    checks++;
    if (out0_req_vld !== 1'b0) begin
      failures++;
      $display("FAIL sr_out_drain: vld=%b required 0", out0_req_vld);
    end
    tick();
    out0_ack_vld  = 1'b1;
    out0_ack_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (out0_ack_rdy !== 1'b1) begin
      failures++;
      $display("FAIL sr_ack_rdy: got %b required 1", out0_ack_rdy);
    end
    tick();
    out0_ack_vld = 1'b0;
    checks++;
    if (in0_ack_vld !== 1'b1 || in0_ack_tgt_id !== 4'd6 || in0_ack_src_id !== 4'd2 ||
        in0_ack_opcode !== 1'b0 || in0_ack_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sr_ack: vld=%b tgt=%h src=%h op=%b data=%h required 1/6/2/0/deadbeef",
               in0_ack_vld, in0_ack_tgt_id, in0_ack_src_id, in0_ack_opcode, in0_ack_data);
    end
    tick();
    checks++;
    if (in0_ack_vld !== 1'b0 || mon_ack.size() != 1) begin
      failures++;
      $display("FAIL sr_ack_once: vld=%b acks=%0d required 0/1", in0_ack_vld, mon_ack.size());
    end
  endtask

  task automatic test_outstanding_limit();
    bit blocked;
    bit drop;
    bit ok;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_req(32'h1000 + 32'(i * 4), 32'(i), 4'hF, 1'(i & 1), 4'(i), 4'd2);
      #1;
      checks++;
      if (in0_req_rdy !== 1'b1) begin
        failures++;
        $display("FAIL ol_accept_%0d: rdy=%b required 1", i, in0_req_rdy);
      end
      tick();
    end
    drive_req(32'h1014, 32'd5, 4'hF, 1'b1, 4'd5, 4'd2);
    blocked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (in0_req_rdy !== 1'b0) blocked = 1'b0;
      tick();
    end
    checks++;
    if (!blocked || mon_in.size() != 4) begin
      failures++;
      $display("FAIL ol_full_blocks: blocked=%b accepted=%0d required 1/4", blocked, mon_in.size());
    end
    for (int k = 0; k < 4; k++) begin
      out0_ack_vld  = 1'b1;
      out0_ack_data = 32'hA000_0000 + 32'(k);
      #1;
      drop = in0_req_vld && in0_req_rdy;
      tick();
      if (drop) in0_req_vld = 1'b0;
    end
    out0_ack_vld = 1'b0;
    ok = 1'b1;
    if (in0_req_vld) wait_accept(ok);
    tick();
    tick();
    checks++;
    if (!ok || mon_in.size() != 5 || mon_in[mon_in.size()-1].src !== 4'd5) begin
      failures++;
      $display("FAIL ol_req5_accepted: accepted=%0d ok=%b required 5/1", mon_in.size(), ok);
    end
    checks++;
    if (mon_ack.size() != 4) begin
      failures++;
      $display("FAIL ol_ack_count: got %0d required 4", mon_ack.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (mon_ack[k].tgt !== 4'(k + 1) || mon_ack[k].data !== 32'hA000_0000 + 32'(k) ||
            mon_ack[k].op !== 1'((k + 1) & 1)) begin
          failures++;
          $display("FAIL ol_ack_%0d: tgt=%h data=%h op=%b required %0d/%h/%b", k,
                   mon_ack[k].tgt, mon_ack[k].data, mon_ack[k].op, k + 1,
                   32'hA000_0000 + 32'(k), 1'((k + 1) & 1));
        end
      end
    end
  endtask

  task automatic test_simul_push_pop();
    bit drop;
    bit ok;
    bit ok2;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_req(32'h2000 + 32'(i), 32'(i), 4'h3, 1'b0, 4'(i), 4'd2);
      tick();
    end
    drive_req(32'h2004, 32'd4, 4'h3, 1'b1, 4'd4, 4'd2);
    out0_ack_vld  = 1'b1;
    out0_ack_data = 32'hB000_0000;
    #1;
    checks++;
    if (in0_req_rdy !== 1'b1 || out0_ack_rdy !== 1'b1) begin
      failures++;
      $display("FAIL sp_both: req_rdy=%b ack_rdy=%b required 1/1", in0_req_rdy, out0_ack_rdy);
    end
    tick();
    in0_req_vld  = 1'b0;
    out0_ack_vld = 1'b0;
    drive_req(32'h2005, 32'd5, 4'h3, 1'b0, 4'd5, 4'd2);
    #1;
    checks++;
    if (in0_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL sp_fourth: rdy=%b required 1", in0_req_rdy);
    end
    tick();
    drive_req(32'h2006, 32'd6, 4'h3, 1'b1, 4'd6, 4'd2);
    #1;
    checks++;
    if (in0_req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL sp_full: rdy=%b required 0", in0_req_rdy);
    end
    tick();
    for (int k = 1; k <= 4; k++) begin
      out0_ack_vld  = 1'b1;
      out0_ack_data = 32'hB000_0000 + 32'(k);
      #1;
      drop = in0_req_vld && in0_req_rdy;
      tick();
      if (drop) in0_req_vld = 1'b0;
    end
    out0_ack_vld = 1'b0;
    ok = 1'b1;
    if (in0_req_vld) wait_accept(ok);
    tick();
    dev_ack(32'hB000_0005, ok2);
    tick();
    tick();
    checks++;
    if (!ok || !ok2 || mon_ack.size() != 6) begin
      failures++;
      $display("FAIL sp_ack_count: got %0d ok=%b/%b required 6", mon_ack.size(), ok, ok2);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (mon_ack[k].tgt !== 4'(k + 1) || mon_ack[k].data !== 32'hB000_0000 + 32'(k)) begin
          failures++;
          $display("FAIL sp_ack_%0d: tgt=%h data=%h required %0d/%h", k,
                   mon_ack[k].tgt, mon_ack[k].data, k + 1, 32'hB000_0000 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit ok2;
    bit stable;
    bit stalled;
    apply_reset();
    send_req(32'h3000, 1'b0, 4'd7, 4'd2, ok);
    send_req(32'h3004, 1'b1, 4'd8, 4'd2, ok2);
    tick();
    in0_ack_rdy   = 1'b0;
    out0_ack_vld  = 1'b1;
    out0_ack_data = 32'hC000_0001;
    #1;
    checks++;
    if (!ok || !ok2 || out0_ack_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_ack: rdy=%b ok=%b/%b required 1", out0_ack_rdy, ok, ok2);
    end
    tick();
    out0_ack_data = 32'hC000_0002;
    stable  = 1'b1;
    stalled = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in0_ack_vld !== 1'b1 || in0_ack_data !== 32'hC000_0001 ||
          in0_ack_tgt_id !== 4'd7 || in0_ack_opcode !== 1'b0) stable = 1'b0;
      if (out0_ack_rdy !== 1'b0) stalled = 1'b0;
      tick();
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold: data=%h tgt=%h required c0000001/7", in0_ack_data, in0_ack_tgt_id);
    end
    checks++;
    if (!stalled || mon_dev_ack.size() != 1) begin
      failures++;
      $display("FAIL bp_stall: stalled=%b dev_acks=%0d required 1/1", stalled, mon_dev_ack.size());
    end
    in0_ack_rdy = 1'b1;
    #1;
    checks++;
    if (out0_ack_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: rdy=%b required 1", out0_ack_rdy);
    end
    tick();
    out0_ack_vld = 1'b0;
    checks++;
    if (in0_ack_vld !== 1'b1 || in0_ack_data !== 32'hC000_0002 ||
        in0_ack_tgt_id !== 4'd8 || in0_ack_opcode !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: vld=%b data=%h tgt=%h op=%b required 1/c0000002/8/1",
               in0_ack_vld, in0_ack_data, in0_ack_tgt_id, in0_ack_opcode);
    end
    tick();
    checks++;
    if (mon_ack.size() != 2 || in0_ack_vld !== 1'b0) begin
      failures++;
      $display("FAIL bp_order: acks=%0d vld=%b required 2/0", mon_ack.size(), in0_ack_vld);
    end else if (mon_ack[0].data !== 32'hC000_0001 || mon_ack[0].tgt !== 4'd7) begin
      failures++;
      $display("FAIL bp_order: first data=%h tgt=%h required c0000001/7", mon_ack[0].data, mon_ack[0].tgt);
    end
  endtask

  task automatic test_misroute();
    bit ok;
    bit ok2;
    apply_reset();
    send_req(32'h4000, 1'b1, 4'd9, 4'd3, ok);
    checks++;
    if (!ok || err_misroute !== 1'b1) begin
      failures++;
      $display("FAIL mr_set: err=%b ok=%b required 1", err_misroute, ok);
    end
    send_req(32'h4004, 1'b0, 4'd10, 4'd2, ok);
    tick();
    dev_ack(32'h0000_1111, ok);
    dev_ack(32'h0000_2222, ok2);
    tick();
    tick();
    checks++;
    if (err_misroute !== 1'b1) begin
      failures++;
      $display("FAIL mr_sticky: err=%b required 1", err_misroute);
    end
    checks++;
    if (!ok || !ok2 || mon_ack.size() != 2) begin
      failures++;
      $display("FAIL mr_acks: got %0d required 2", mon_ack.size());
    end else if (mon_ack[0].tgt !== 4'd9 || mon_ack[0].op !== 1'b1 || mon_ack[1].tgt !== 4'd10) begin
      failures++;
      $display("FAIL mr_acks: tgt0=%h op0=%b tgt1=%h required 9/1/a",
               mon_ack[0].tgt, mon_ack[0].op, mon_ack[1].tgt);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit ok2;
    apply_reset();
    send_req(32'h5000, 1'b0, 4'd1, 4'd3, ok);
    send_req(32'h5004, 1'b0, 4'd2, 4'd2, ok2);
    tick();
    in0_ack_rdy = 1'b0;
    dev_ack(32'h0000_E001, ok);
    out0_req_rdy = 1'b0;
    drive_req(32'h5008, 32'h0, 4'h1, 1'b1, 4'd3, 4'd2);
    tick();
    in0_req_vld = 1'b0;
    checks++;
    if (!ok || !ok2 || in0_ack_vld !== 1'b1 || out0_req_vld !== 1'b1 || err_misroute !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre: ack_vld=%b req_vld=%b err=%b required 1/1/1",
               in0_ack_vld, out0_req_vld, err_misroute);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in0_ack_vld !== 1'b0 || out0_req_vld !== 1'b0 || err_misroute !== 1'b0) begin
      failures++;
      $display("FAIL rm_async: ack_vld=%b req_vld=%b err=%b required 0/0/0",
               in0_ack_vld, out0_req_vld, err_misroute);
    end
    tick();
    mon_in.delete();
    mon_out.delete();
    mon_dev_ack.delete();
    mon_ack.delete();
    rst_n = 1'b1;
    out0_req_rdy = 1'b1;
    in0_ack_rdy  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (mon_ack.size() != 0 || mon_out.size() != 0 || in0_req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rm_no_stale: acks=%0d dev_reqs=%0d rdy=%b required 0/0/1",
               mon_ack.size(), mon_out.size(), in0_req_rdy);
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    int  sent;
    int  outst;
    int  dev_pending;
    int  over;
    bit  in_x;
    bit  dr_x;
    bit  da_x;
    bit  done;
    bit  exp_err;
    apply_reset();
    sent = 0;
    outst = 0;
    dev_pending = 0;
    over = 0;
    done = 1'b0;
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (!in0_req_vld && sent < N && $urandom_range(0, 2) != 0) begin
        drive_req($urandom, $urandom, 4'($urandom), 1'($urandom),
                  4'($urandom), ($urandom_range(0, 15) == 0) ? 4'd3 : 4'd2);
      end
      out0_req_rdy = ($urandom_range(0, 3) != 0);
      in0_ack_rdy  = ($urandom_range(0, 3) != 0);
      if (!out0_ack_vld && dev_pending > 0 && $urandom_range(0, 1) != 0) begin
        out0_ack_vld  = 1'b1;
        out0_ack_data = $urandom;
      end
      #1;
      in_x = in0_req_vld && in0_req_rdy;
      dr_x = out0_req_vld && out0_req_rdy;
      da_x = out0_ack_vld && out0_ack_rdy;
      if (in_x && outst >= 4) over++;
      if (in_x && in0_req_tgt_id != 4'd2) exp_err = 1'b1;
      tick();
      if (in_x) begin
        in0_req_vld = 1'b0;
        sent++;
        outst++;
      end
      if (dr_x) dev_pending++;
      if (da_x) begin
        out0_ack_vld = 1'b0;
        dev_pending--;
        outst--;
      end
      if (sent == N && outst == 0 && !in0_ack_vld && !out0_req_vld) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    checks++;
    if (!done || over != 0) begin
      failures++;
      $display("FAIL rnd_progress: done=%b sent=%0d over_limit=%0d required 1/%0d/0", done, sent, over, N);
    end
    checks++;
    if (err_misroute !== exp_err) begin
      failures++;
      $display("FAIL rnd_err: got %b required %b", err_misroute, exp_err);
    end
    checks++;
    if (mon_in.size() != N || mon_out.size() != N || mon_ack.size() != N || mon_dev_ack.size() != N) begin
      failures++;
      $display("FAIL rnd_counts: in=%0d out=%0d dev_ack=%0d ack=%0d required %0d each",
               mon_in.size(), mon_out.size(), mon_dev_ack.size(), mon_ack.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (mon_out[i].addr !== mon_in[i].addr || mon_out[i].data !== mon_in[i].data ||
            mon_out[i].strb !== mon_in[i].strb || mon_out[i].op !== mon_in[i].op) begin
          failures++;
          $display("FAIL rnd_req_%0d: addr=%h data=%h strb=%h op=%b required %h/%h/%h/%b", i,
                   mon_out[i].addr, mon_out[i].data, mon_out[i].strb, mon_out[i].op,
                   mon_in[i].addr, mon_in[i].data, mon_in[i].strb, mon_in[i].op);
        end
        checks++;
        if (mon_ack[i].data !== mon_dev_ack[i] || mon_ack[i].tgt !== mon_in[i].src ||
            mon_ack[i].op !== mon_in[i].op || mon_ack[i].src !== 4'd2) begin
          failures++;
          $display("FAIL rnd_ack_%0d: data=%h tgt=%h op=%b src=%h required %h/%h/%b/2", i,
                   mon_ack[i].data, mon_ack[i].tgt, mon_ack[i].op, mon_ack[i].src,
                   mon_dev_ack[i], mon_in[i].src, mon_in[i].op);
        end
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b1;
    in0_req_vld    = 1'b0;
    in0_req_addr   = '0;
    in0_req_data   = '0;
    in0_req_strb   = '0;
    in0_req_opcode = 1'b0;
    in0_req_src_id = '0;
    in0_req_tgt_id = '0;
    in0_ack_rdy    = 1'b1;
    out0_req_rdy   = 1'b1;
    out0_ack_vld   = 1'b0;
    out0_ack_data  = '0;
    test_reset();
    test_single_read();
    test_outstanding_limit();
    test_simul_push_pop();
    test_backpressure();
    test_misroute();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
